ppu_mem_arbiter: RTL and testbench

// Parametrised PPU memory-port arbiter, successor to the single vblank-select mux in front of VRAM/palette.

---
 rtl/ppu_mem_arbiter_pkg.sv | 25 ++
 rtl/ppu_mem_arbiter_if.sv | 42 ++++
 rtl/ppu_rr_arbiter.sv | 50 +++++
 rtl/ppu_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ppu_mem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_mem_arbiter_pkg.sv
// Shared types and constants for the PPU memory arbiter:
// address map, return-pipeline tag, palette aliasing.
package ppu_mem_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam logic [13:0] VRAM_MIRROR_LO = 14'h3000;
    localparam logic [13:0] PAL_BASE       = 14'h3F00;
    localparam logic [13:0] MIRROR_OFS     = 14'h1000;

    typedef struct packed {
        logic       valid;
        logic [2:0] ch_id;
        logic       is_pal;
    } ret_tag_t;

    // Sprite-palette entry 0 of each group shares storage with the bg entry.
    function automatic logic [4:0] pal_alias(input logic [4:0] p);
        return (p[4] && p[1:0] == 2'b00) ? {1'b0, p[3:0]} : p;
    endfunction

endpackage

// File: rtl/ppu_mem_arbiter_if.sv
// Requester and memory-port bundle of the PPU memory arbiter.
// slave = arbiter side, master = requesters plus memories.
interface ppu_mem_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic                     render_active;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [DATA_W-1:0]        ch_rdata;
    logic [13:0]              vram_addr;
    logic                     vram_we;
    logic [DATA_W-1:0]        vram_wdata;
    logic [DATA_W-1:0]        vram_rdata;
    logic [4:0]               pal_addr;
    logic                     pal_we;
    logic [DATA_W-1:0]        pal_wdata;
    logic [DATA_W-1:0]        pal_rdata;
    logic                     starve_err;

    modport slave (
        input  render_active, ch_req, ch_we, ch_addr, ch_wdata,
        input  vram_rdata, pal_rdata,
        output ch_gnt, ch_rvalid, ch_rdata,
        output vram_addr, vram_we, vram_wdata,
        output pal_addr, pal_we, pal_wdata, starve_err
    );

    modport master (
        output render_active, ch_req, ch_we, ch_addr, ch_wdata,
        output vram_rdata, pal_rdata,
        input  ch_gnt, ch_rvalid, ch_rdata,
        input  vram_addr, vram_we, vram_wdata,
        input  pal_addr, pal_we, pal_wdata, starve_err
    );

endinterface

// File: rtl/ppu_rr_arbiter.sv
// One-hot grant selector: fixed lowest-index priority or
// round-robin starting at a rotating pointer.
module ppu_rr_arbiter
    import ppu_mem_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] eligible,
    output logic [NUM_CH-1:0] gnt
);
    localparam int IW = $clog2(NUM_CH);

    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [NUM_CH-1:0] cand;
    logic              found;
    int                start;
    int                idx;
    int                win;

    always_comb begin
        cand  = req & eligible;
        start = (ARB_MODE == int'(ARB_RR)) ? int'(ptr_q) : 0;
        gnt   = '0;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = start + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && cand[IW'(idx)]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) gnt[IW'(win)] = 1'b1;
        ptr_d = ptr_q;
        if (found) ptr_d = (win == NUM_CH - 1) ? '0 : IW'(win + 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ppu_mem_arbiter.sv
// PPU memory arbiter: grants one requester per cycle onto VRAM or
// palette, mirrors $3000-$3EFF, tags reads, watches for starvation.
module ppu_mem_arbiter
    import ppu_mem_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_LIM = 1023
) (
    input logic clk,
    input logic reset,
    ppu_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt;
    logic              any_gnt;
    logic              sel_we;
    logic [2:0]        sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [13:0]       a;
    logic [13:0]       vaddr;
    logic [4:0]        paddr;
    logic              is_pal;

    logic [13:0]       vram_addr_q, vram_addr_d;
    logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
    logic [4:0]        pal_addr_q, pal_addr_d;
    logic [DATA_W-1:0] pal_wdata_q, pal_wdata_d;
    ret_tag_t          ret_q [MEM_LAT];
    ret_tag_t          ret_d [MEM_LAT];
    ret_tag_t          tail;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic              starve_q, starve_d;
    logic [NUM_CH-1:0] rvalid;

    // Nothing is eligible while reset is held so outputs stay quiet.
    always_comb begin
        elig = '0;
        if (!reset) elig = bus.render_active ? NUM_CH'(1) : '1;
    end

    ppu_rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.ch_req),
        .eligible (elig),
        .gnt      (gnt)
    );

    always_comb begin
        sel_id    = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_id    = 3'(i);
                sel_we    = bus.ch_we[i];
                sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    generate
        if (ADDR_W > 14) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^sel_addr[ADDR_W-1:14];
        end
    endgenerate

    assign any_gnt = |gnt;
    assign a       = sel_addr[13:0];
    assign is_pal  = (a >= PAL_BASE);
    assign vaddr   = (a >= VRAM_MIRROR_LO) ? a - MIRROR_OFS : a;
    assign paddr   = pal_alias(a[4:0]);

    always_comb begin
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        pal_addr_d   = pal_addr_q;
        pal_wdata_d  = pal_wdata_q;
        if (any_gnt && !is_pal) begin
            vram_addr_d = vaddr;
            if (sel_we) vram_wdata_d = sel_wdata;
        end
        if (any_gnt && is_pal) begin
            pal_addr_d = paddr;
            if (sel_we) pal_wdata_d = sel_wdata;
        end
    end

    always_comb begin
        ret_d[0].valid  = any_gnt && !sel_we;
        ret_d[0].ch_id  = sel_id;
        ret_d[0].is_pal = is_pal;
        for (int s = 1; s < MEM_LAT; s++) ret_d[s] = ret_q[s-1];
    end

    // Counters only advance outside the render window.
    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (i != 0 && bus.ch_req[i] && !gnt[i]) begin
                cnt_d[i] = cnt_q[i];
                if (!bus.render_active && cnt_q[i] != LIM)
                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (cnt_d[i] == LIM) starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            pal_addr_q   <= '0;
            pal_wdata_q  <= '0;
            ret_q        <= '{default: '0};
            cnt_q        <= '{default: '0};
            starve_q     <= 1'b0;
        end else begin
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            pal_addr_q   <= pal_addr_d;
            pal_wdata_q  <= pal_wdata_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign tail = ret_q[MEM_LAT-1];

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NUM_CH; i++)
            rvalid[i] = tail.valid && (tail.ch_id == 3'(i));
    end

    assign bus.ch_gnt     = gnt;
    assign bus.ch_rvalid  = rvalid;
    assign bus.ch_rdata   = !tail.valid ? '0 :
                            tail.is_pal ? bus.pal_rdata : bus.vram_rdata;
    assign bus.vram_addr  = vram_addr_d;
    assign bus.vram_we    = any_gnt && sel_we && !is_pal;
    assign bus.vram_wdata = vram_wdata_d;
    assign bus.pal_addr   = pal_addr_d;
    assign bus.pal_we     = any_gnt && sel_we && is_pal;
    assign bus.pal_wdata  = pal_wdata_d;
    assign bus.starve_err = starve_q;

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Directed bench for ppu_mem_arbiter: a fixed-priority instance with
// VRAM/palette models and a round-robin instance.
module tb_ppu_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errs = 0;

    always #5 clk = ~clk;

    ppu_mem_arbiter_if #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8)) bf ();
    ppu_mem_arbiter_if #(.NUM_CH(3), .ADDR_W(16), .DATA_W(8)) br ();

    ppu_mem_arbiter #(
        .NUM_CH(3), .ADDR_W(16), .DATA_W(8),
        .MEM_LAT(2), .ARB_MODE(0), .STARVE_LIM(8)
    ) dut_f (
        .clk   (clk),
        .reset (reset),
        .bus   (bf.slave)
    );

    ppu_mem_arbiter #(
        .NUM_CH(3), .ADDR_W(16), .DATA_W(8),
        .MEM_LAT(1), .ARB_MODE(1), .STARVE_LIM(1023)
    ) dut_r (
        .clk   (clk),
        .reset (reset),
        .bus   (br.slave)
    );

    logic [7:0] vram [16384];
    logic [7:0] pal [32];
    logic [7:0] vrd1, vrd2, prd1, prd2;

    always @(posedge clk) begin
        if (bf.vram_we) vram[bf.vram_addr] <= bf.vram_wdata;
        if (bf.pal_we) pal[bf.pal_addr] <= bf.pal_wdata;
        vrd1 <= vram[bf.vram_addr];
        vrd2 <= vrd1;
        prd1 <= pal[bf.pal_addr];
        prd2 <= prd1;
    end

    assign bf.vram_rdata = vrd2;
    assign bf.pal_rdata  = prd2;
    assign br.vram_rdata = 8'h00;
    assign br.pal_rdata  = 8'h00;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int ch, logic rq, logic we,
                       logic [15:0] ad, logic [7:0] wd);
        bf.ch_req[ch]            = rq;
        bf.ch_we[ch]             = we;
        bf.ch_addr[ch*16 +: 16]  = ad;
        bf.ch_wdata[ch*8 +: 8]   = wd;
    endtask

    logic [2:0] rr_exp [6];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bf.render_active = 1'b0;
        bf.ch_req = '0;
        bf.ch_we = '0;
        bf.ch_addr = '0;
        bf.ch_wdata = '0;
        br.render_active = 1'b0;
        br.ch_req = '0;
        br.ch_we = '0;
        br.ch_addr = '0;
        br.ch_wdata = '0;
        reset = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(bf.ch_gnt), 0);
        check("rst_rvalid", 32'(bf.ch_rvalid), 0);
        check("rst_rdata", 32'(bf.ch_rdata), 0);
        check("rst_vram_we", 32'(bf.vram_we), 0);
        check("rst_pal_we", 32'(bf.pal_we), 0);
        check("rst_vram_addr", 32'(bf.vram_addr), 0);
        check("rst_starve", 32'(bf.starve_err), 0);
        reset = 1'b0;

        // round-robin rotation
        br.ch_req = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rr_gnt", 32'(br.ch_gnt), 32'(rr_exp[k]));
            tick();
        end
        br.ch_req = '0;

        // mirroring and palette aliasing
        drv(1, 1, 1, 16'h3005, 8'hAB);
        #1;
        check("mir_gnt", 32'(bf.ch_gnt), 32'b010);
        check("mir_vaddr", 32'(bf.vram_addr), 32'h2005);
        check("mir_vwe", 32'(bf.vram_we), 1);
        check("mir_vwdata", 32'(bf.vram_wdata), 32'hAB);
        check("mir_pwe0", 32'(bf.pal_we), 0);
        tick();
        drv(1, 1, 1, 16'h3F10, 8'h11);
        #1;
        check("alias_paddr", 32'(bf.pal_addr), 0);
        check("alias_pwe", 32'(bf.pal_we), 1);
        check("alias_vwe", 32'(bf.vram_we), 0);
        tick();
        drv(1, 1, 0, 16'h3F00, 8'h00);
        #1;
        check("palrd_gnt", 32'(bf.ch_gnt), 32'b010);
        check("palrd_paddr", 32'(bf.pal_addr), 0);
        check("palrd_pwe", 32'(bf.pal_we), 0);
        tick();
        drv(1, 0, 0, 16'h0000, 8'h00);
        #1;
        check("wr_no_rvalid", 32'(bf.ch_rvalid), 0);
        check("vaddr_hold", 32'(bf.vram_addr), 32'h2005);
        check("idle_vwe", 32'(bf.vram_we), 0);
        tick();
        check("palrd_rvalid", 32'(bf.ch_rvalid), 32'b010);
        check("palrd_rdata", 32'(bf.ch_rdata), 32'h11);
        tick();

        // fixed priority, same-cycle reads
        drv(1, 1, 0, 16'h2005, 8'h00);
        drv(2, 1, 0, 16'h2005, 8'h00);
        #1;
        check("fp_gnt1", 32'(bf.ch_gnt), 32'b010);
        check("fp_vaddr", 32'(bf.vram_addr), 32'h2005);
        tick();
        drv(1, 0, 0, 16'h0000, 8'h00);
        #1;
        check("fp_gnt2", 32'(bf.ch_gnt), 32'b100);
        tick();
        drv(2, 0, 0, 16'h0000, 8'h00);
        #1;
        check("fp_rv1", 32'(bf.ch_rvalid), 32'b010);
        check("fp_rd1", 32'(bf.ch_rdata), 32'hAB);
        tick();
        check("fp_rv2", 32'(bf.ch_rvalid), 32'b100);
        check("fp_rd2", 32'(bf.ch_rdata), 32'hAB);
        tick();
        check("fp_rv_idle", 32'(bf.ch_rvalid), 0);

        // render window blocks non-render channels
        bf.render_active = 1'b1;
        drv(1, 1, 1, 16'h2400, 8'h77);
        drv(0, 1, 0, 16'h2005, 8'h00);
        #1;
        check("ra_gnt0", 32'(bf.ch_gnt), 32'b001);
        tick();
        drv(0, 0, 0, 16'h0000, 8'h00);
        #1;
        check("ra_blk1", 32'(bf.ch_gnt), 0);
        tick();
        check("ra_blk2", 32'(bf.ch_gnt), 0);
        check("ra_rv0", 32'(bf.ch_rvalid), 32'b001);
        check("ra_rd0", 32'(bf.ch_rdata), 32'hAB);
        bf.render_active = 1'b0;
        #1;
        check("ra_gnt1", 32'(bf.ch_gnt), 32'b010);
        check("ra_vaddr", 32'(bf.vram_addr), 32'h2400);
        check("ra_vwe", 32'(bf.vram_we), 1);
        tick();
        drv(1, 0, 0, 16'h0000, 8'h00);
        #1;
        check("ra_no_rv", 32'(bf.ch_rvalid), 0);
        tick();

        // starvation of ch2 behind continuous ch1
        check("st_pre", 32'(bf.starve_err), 0);
        drv(1, 1, 0, 16'h0000, 8'h00);
        drv(2, 1, 0, 16'h0010, 8'h00);
        #1;
        check("st_gnt", 32'(bf.ch_gnt), 32'b010);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("st_flag", 32'(bf.starve_err), 32'(k == 8));
        end
        drv(1, 0, 0, 16'h0000, 8'h00);
        drv(2, 0, 0, 16'h0000, 8'h00);
        tick();
        tick();
        tick();
        check("st_sticky", 32'(bf.starve_err), 1);

        // reset with a read in flight
        drv(1, 1, 0, 16'h2005, 8'h00);
        #1;
        check("rs_gnt", 32'(bf.ch_gnt), 32'b010);
        tick();
        drv(1, 0, 0, 16'h0000, 8'h00);
        reset = 1'b1;
        #1;
        check("rs_gnt0", 32'(bf.ch_gnt), 0);
        check("rs_rvalid", 32'(bf.ch_rvalid), 0);
        check("rs_rdata", 32'(bf.ch_rdata), 0);
        check("rs_vaddr", 32'(bf.vram_addr), 0);
        check("rs_vwe", 32'(bf.vram_we), 0);
        check("rs_starve", 32'(bf.starve_err), 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rs_drop", 32'(bf.ch_rvalid), 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
